// File: rtl/pkt_input_fifo.sv
// ---------------------------------------------------------------------------
// pkt_input_fifo
//
// Single-packet store-and-forward buffer that sits in front of
// pipeline_datapath. One packet is received into an internal dual-port buffer.
// The buffer is then handed to a processor for read/modify. Finally the packet
// is streamed out. Receive, process and send never overlap.
//
// Optional build macro: PKT_INPUT_FIFO_STATS_EN
//   When defined, the 32-bit outputs pkt_count and trunc_count are added.
//   pkt_count    : packets sent.
//   trunc_count  : packets sent that had been truncated.
//
// Ports
//   clk, reset                 : system clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr      : upstream word stream
//   in_rdy                     : upstream may write (receive phase only)
//   out_data/out_ctrl/out_wr   : stream toward pipeline_datapath
//   out_rdy                    : downstream may accept a word
//   proc_addr/proc_we/proc_wdata : processor buffer access (data lane writes)
//   proc_rdata                 : processor read data, one cycle after proc_addr
//   proc_done                  : processor hands the buffer back, start send
//   pkt_ready                  : packet resident, processor owns the buffer
//   pkt_len                    : index of the last stored word
//   overflow                   : current packet was truncated to fit
// ---------------------------------------------------------------------------
module pkt_input_fifo #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic                      in_wr,
    output logic                      in_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    input  logic                      out_rdy,
    input  logic [MEM_ADDR_WIDTH-1:0] proc_addr,
    input  logic                      proc_we,
    input  logic [DATA_WIDTH-1:0]     proc_wdata,
    output logic [DATA_WIDTH-1:0]     proc_rdata,
    input  logic                      proc_done,
    output logic                      pkt_ready,
    output logic [MEM_ADDR_WIDTH-1:0] pkt_len,
    output logic                      overflow
`ifdef PKT_INPUT_FIFO_STATS_EN
    ,
    output logic [31:0]               pkt_count,
    output logic [31:0]               trunc_count
`endif
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RX_HDR     = 3'd1;
    localparam logic [2:0] RX_PAYLOAD = 3'd2;
    localparam logic [2:0] PROC       = 3'd3;
    localparam logic [2:0] TX         = 3'd4;
    localparam logic [2:0] TX_DRAIN   = 3'd5;

    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = MEM_ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0]     mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0]     mem_ctrl [DEPTH];

    logic [2:0]                state;
    logic [2:0]                state_next;
    logic [MEM_ADDR_WIDTH-1:0] wptr;
    logic [MEM_ADDR_WIDTH-1:0] rptr;

    logic                      rx_accept;
    logic                      in_is_ctrl;
    logic                      rx_last;

    logic                      mem_we_data;
    logic                      mem_we_ctrl;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [CTRL_WIDTH-1:0]     mem_wctrl;

    // in_rdy is registered from the next state, so it is true exactly while
    // the FSM sits in a receive state (and low during the reset cycle).
    assign rx_accept  = in_wr && in_rdy;
    assign in_is_ctrl = (in_ctrl != '0);
    assign rx_last    = (state == RX_PAYLOAD) && in_is_ctrl;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch).
        state_next = state;
        case (state)
            IDLE:       if (rx_accept && in_is_ctrl)  state_next = RX_HDR;
            RX_HDR:     if (rx_accept && !in_is_ctrl) state_next = RX_PAYLOAD;
            RX_PAYLOAD: if (rx_accept && in_is_ctrl)  state_next = PROC;
            PROC:       if (proc_done)                state_next = TX;
            TX:         if (out_rdy && (rptr == pkt_len)) state_next = TX_DRAIN;
            TX_DRAIN:   state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Buffer write port: receive path writes data+ctrl, processor writes the
    // data lane only. The two never coincide because they live in different
    // states.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we_data = 1'b0;
        mem_we_ctrl = 1'b0;
        mem_waddr   = wptr;
        mem_wdata   = in_data;
        mem_wctrl   = in_ctrl;
        case (state)
            IDLE: begin
                if (rx_accept && in_is_ctrl) begin
                    mem_we_data = 1'b1;
                    mem_we_ctrl = 1'b1;
                    mem_waddr   = '0;
                end
            end
            RX_HDR, RX_PAYLOAD: begin
                // Once truncated, only the end-of-packet word is written; wptr
                // is parked on the last address so it overwrites that slot and
                // the end marker survives.
                if (rx_accept && (!overflow || rx_last)) begin
                    mem_we_data = 1'b1;
                    mem_we_ctrl = 1'b1;
                end
            end
            PROC: begin
                if (proc_we) begin
                    mem_we_data = 1'b1;
                    mem_waddr   = proc_addr;
                    mem_wdata   = proc_wdata;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the buffer array has no reset; packet contents are don't-care
    // until written, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_we_data) mem_data[mem_waddr] <= mem_wdata;
            if (mem_we_ctrl) mem_ctrl[mem_waddr] <= mem_wctrl;
        end
    end

    // -----------------------------------------------------------------------
    // State, pointers and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            in_rdy     <= 1'b0;
            out_wr     <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            proc_rdata <= '0;
            pkt_ready  <= 1'b0;
            pkt_len    <= '0;
            overflow   <= 1'b0;
`ifdef PKT_INPUT_FIFO_STATS_EN
            pkt_count   <= '0;
            trunc_count <= '0;
`endif
        end else begin
            state  <= state_next;
            in_rdy <= (state_next == IDLE) || (state_next == RX_HDR) ||
                      (state_next == RX_PAYLOAD);
            out_wr <= 1'b0;

            case (state)
                IDLE: begin
                    // Stray words (ctrl==0) are dropped without side effects.
                    if (rx_accept && in_is_ctrl) wptr <= ADDR_ONE;
                end
                RX_HDR, RX_PAYLOAD: begin
                    if (rx_accept) begin
                        if (rx_last) begin
                            pkt_len <= wptr;
                            wptr    <= '0;
                        end else if (wptr == LAST_ADDR) begin
                            overflow <= 1'b1;
                        end else begin
                            wptr <= wptr + ADDR_ONE;
                        end
                    end
                end
                PROC: begin
                    proc_rdata <= mem_data[proc_addr];
                    // pkt_ready rises one cycle after entering PROC.
                    pkt_ready  <= !proc_done;
                    if (proc_done) rptr <= '0;
                end
                TX: begin
                    // The word read this cycle is presented next cycle; out_rdy
                    // is only consulted when deciding to issue the read.
                    if (out_rdy) begin
                        out_wr   <= 1'b1;
                        out_data <= mem_data[rptr];
                        out_ctrl <= mem_ctrl[rptr];
                        if (rptr != pkt_len) rptr <= rptr + ADDR_ONE;
                    end
                end
                TX_DRAIN: begin
                    overflow <= 1'b0;
`ifdef PKT_INPUT_FIFO_STATS_EN
                    pkt_count <= pkt_count + 32'd1;
                    if (overflow) trunc_count <= trunc_count + 32'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_input_fifo.sv
// ---------------------------------------------------------------------------
// tb_pkt_input_fifo
//
// Self-checking bench for pkt_input_fifo. A packet-level reference model
// (queue of input words -> stored image -> expected output sequence) is kept
// in the bench. One negedge process compares out_wr every cycle and each
// emitted word against the model. Directed packets pin the model with literal
// expectations; a randomized loop covers lengths, strays, processor edits
// and downstream back-pressure.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pkt_input_fifo;

    localparam int DW    = 64;
    localparam int CW    = DW / 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } word_t;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [DW-1:0] in_data    = '0;
    logic [CW-1:0] in_ctrl    = '0;
    logic          in_wr      = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy    = 1'b1;
    logic [AW-1:0] proc_addr  = '0;
    logic          proc_we    = 1'b0;
    logic [DW-1:0] proc_wdata = '0;
    logic [DW-1:0] proc_rdata;
    logic          proc_done  = 1'b0;
    logic          pkt_ready;
    logic [AW-1:0] pkt_len;
    logic          overflow;
`ifdef PKT_INPUT_FIFO_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   trunc_count;
`endif

    always #5 clk = ~clk;

    pkt_input_fifo #(
        .DATA_WIDTH    (DW),
        .CTRL_WIDTH    (CW),
        .MEM_ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .proc_addr  (proc_addr),
        .proc_we    (proc_we),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_done  (proc_done),
        .pkt_ready  (pkt_ready),
        .pkt_len    (pkt_len),
        .overflow   (overflow)
`ifdef PKT_INPUT_FIFO_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .trunc_count(trunc_count)
`endif
    );

    // ---------------------------------------------------------------- scoring
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- model
    word_t         pkt_q[$];            // words driven for the current packet
    logic [DW-1:0] m_data [DEPTH];      // expected buffer image
    logic [CW-1:0] m_ctrl [DEPTH];
    int            m_len         = 0;
    bit            m_ovf         = 1'b0;
    int            m_pkt_count   = 0;
    int            m_trunc_count = 0;

    // Owned by the compare process
    word_t         exp_out[$];
    word_t         out_log[$];
    bit            exp_wr    = 1'b0;
    bit            tx_phase  = 1'b0;
    int            tx_total  = 0;
    int            tx_issued = 0;

    // Downstream ready pattern: 0 always ready, 1 fixed 1,0,0,1,0,1, 2 random
    int            out_rdy_mode = 0;
    logic [5:0]    rdy_pat      = 6'b101001;
    int            pat_i        = 0;

    always @(posedge clk) begin
        #1;
        case (out_rdy_mode)
            0: out_rdy = 1'b1;
            1: begin
                out_rdy = rdy_pat[pat_i];
                pat_i   = (pat_i + 1) % 6;
            end
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process: a word must appear exactly one cycle after each cycle
    // in which the send phase had words left and downstream was ready.
    always @(negedge clk) begin
        word_t got;
        word_t want;
        word_t w;
        check("out_wr", 64'(out_wr), 64'(exp_wr));
        if (out_wr === 1'b1 && exp_out.size() > 0) begin
            got.data = out_data;
            got.ctrl = out_ctrl;
            want     = exp_out.pop_front();
            check("out_data", got.data, want.data);
            check("out_ctrl", 64'(got.ctrl), 64'(want.ctrl));
            out_log.push_back(got);
        end
        if (reset) begin
            exp_wr    = 1'b0;
            tx_phase  = 1'b0;
            tx_total  = 0;
            tx_issued = 0;
            exp_out.delete();
        end else begin
            exp_wr = tx_phase && out_rdy && (tx_issued < tx_total);
            if (exp_wr) tx_issued++;
            if (proc_done) begin
                tx_phase  = 1'b1;
                tx_issued = 0;
                tx_total  = m_len + 1;
                exp_out.delete();
                out_log.delete();
                for (int i = 0; i <= m_len; i++) begin
                    w.data = m_data[i];
                    w.ctrl = m_ctrl[i];
                    exp_out.push_back(w);
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    // Packet shape: nh header words (ctrl!=0), np payload words (ctrl==0),
    // one end word (ctrl!=0). Directed packets use data = {A0000000, index}.
    task automatic build_packet(input int nh, input int np, input bit directed);
        word_t w;
        int    n;
        pkt_q.delete();
        n = nh + np + 1;
        for (int i = 0; i < n; i++) begin
            if (directed) begin
                w.data = {32'hA000_0000, 32'(i)};
                w.ctrl = (i < nh) ? CW'(8'hFF) : ((i == n - 1) ? CW'(8'h01) : '0);
            end else begin
                w.data = {$urandom, $urandom};
                if (i < nh || i == n - 1) w.ctrl = CW'($urandom_range(1, (1 << CW) - 1));
                else                      w.ctrl = '0;
            end
            pkt_q.push_back(w);
        end
    endtask

    // Stored image: everything fits, or the first DEPTH-1 words followed by
    // the end word in the last slot.
    task automatic load_model();
        int n;
        n = pkt_q.size();
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                m_data[i] = pkt_q[i].data;
                m_ctrl[i] = pkt_q[i].ctrl;
            end
            m_len = n - 1;
            m_ovf = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                m_data[i] = pkt_q[i].data;
                m_ctrl[i] = pkt_q[i].ctrl;
            end
            m_data[DEPTH-1] = pkt_q[n-1].data;
            m_ctrl[DEPTH-1] = pkt_q[n-1].ctrl;
            m_len = DEPTH - 1;
            m_ovf = 1'b1;
        end
    endtask

    task automatic drive_packet(input int n_stray);
        int cyc;
        cyc = 0;
        while (in_rdy !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("in_rdy_before_pkt", 64'(in_rdy), 64'd1);
        for (int i = 0; i < n_stray; i++) begin
            in_data = {$urandom, $urandom};
            in_ctrl = '0;
            in_wr   = 1'b1;
            tick();
        end
        foreach (pkt_q[i]) begin
            in_data = pkt_q[i].data;
            in_ctrl = pkt_q[i].ctrl;
            in_wr   = 1'b1;
            tick();
        end
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        check("pkt_ready_first_proc_cycle", 64'(pkt_ready), 64'd0);
        check("in_rdy_in_proc", 64'(in_rdy), 64'd0);
        tick();
        check("pkt_ready_second_proc_cycle", 64'(pkt_ready), 64'd1);
    endtask

    task automatic process_pkt(input int n_ops, input bit simul);
        logic [DW-1:0] v;
        logic [DW-1:0] exp_v;
        int            a;
        check("pkt_len", 64'(pkt_len), 64'(m_len));
        check("overflow_flag", 64'(overflow), 64'(m_ovf));
        for (int k = 0; k < n_ops; k++) begin
            a = int'($urandom_range(0, m_len));
            if ($urandom_range(0, 1) == 1) begin
                v          = {$urandom, $urandom};
                proc_addr  = AW'(a);
                proc_we    = 1'b1;
                proc_wdata = v;
                m_data[a]  = v;
                tick();
                proc_we    = 1'b0;
            end else begin
                proc_addr = AW'(a);
                exp_v     = m_data[a];
                tick();
                check("proc_rdata", proc_rdata, exp_v);
            end
        end
        if (simul) begin
            a          = int'($urandom_range(0, m_len));
            v          = {$urandom, $urandom};
            proc_addr  = AW'(a);
            proc_we    = 1'b1;
            proc_wdata = v;
            m_data[a]  = v;
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        proc_we   = 1'b0;
        check("pkt_ready_cleared", 64'(pkt_ready), 64'd0);
    endtask

    task automatic finish_pkt();
        int cyc;
        cyc = 0;
        while (in_rdy !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("tx_return_idle", 64'(in_rdy), 64'd1);
        check("tx_word_count", 64'(out_log.size()), 64'(m_len + 1));
        check("tx_words_left", 64'(exp_out.size()), 64'd0);
        check("overflow_cleared", 64'(overflow), 64'd0);
        m_pkt_count++;
        if (m_ovf) m_trunc_count++;
`ifdef PKT_INPUT_FIFO_STATS_EN
        check("pkt_count", 64'(pkt_count), 64'(m_pkt_count));
        check("trunc_count", 64'(trunc_count), 64'(m_trunc_count));
`endif
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int cyc;

        // Reset state
        repeat (3) tick();
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_proc_rdata", proc_rdata, 64'd0);
        check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        check("rst_pkt_len", 64'(pkt_len), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();
        check("in_rdy_after_reset", 64'(in_rdy), 64'd1);

        // Basic packet: 2 hdr, 3 payload, 1 end; processor edit of word 3
        out_rdy_mode = 0;
        build_packet(2, 3, 1'b1);
        load_model();
        drive_packet(2);
        check("t1_pkt_len_lit", 64'(pkt_len), 64'd5);
        proc_addr  = AW'(3);
        proc_we    = 1'b1;
        proc_wdata = 64'hDEADBEEF_00000000;
        m_data[3]  = 64'hDEADBEEF_00000000;
        tick();
        proc_we    = 1'b0;
        tick();
        check("t1_rdata_after_write", proc_rdata, 64'hDEADBEEF_00000000);
        process_pkt(0, 1'b0);
        finish_pkt();
        check("t1_out_count_lit", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            check("t1_word0_lit", out_log[0].data, {32'hA000_0000, 32'd0});
            check("t1_word0_ctrl_lit", 64'(out_log[0].ctrl), 64'hFF);
            check("t1_word2_lit", out_log[2].data, {32'hA000_0000, 32'd2});
            check("t1_word3_lit", out_log[3].data, 64'hDEADBEEF_00000000);
            check("t1_word3_ctrl_lit", 64'(out_log[3].ctrl), 64'd0);
            check("t1_word5_ctrl_lit", 64'(out_log[5].ctrl), 64'h01);
        end

        // Back-pressure pattern 1,0,0,1,0,1 with a simultaneous write+done
        out_rdy_mode = 1;
        build_packet(2, 3, 1'b1);
        load_model();
        drive_packet(0);
        process_pkt(3, 1'b1);
        finish_pkt();
        check("t2_out_count_lit", 64'(out_log.size()), 64'd6);

        // Exactly full buffer: 256 words, no truncation
        out_rdy_mode = 0;
        build_packet(2, 253, 1'b1);
        load_model();
        drive_packet(0);
        check("t3_pkt_len_lit", 64'(pkt_len), 64'd255);
        check("t3_overflow_lit", 64'(overflow), 64'd0);
        process_pkt(0, 1'b0);
        finish_pkt();

        // 300-word packet: truncated to 256 words, end marker kept
        build_packet(2, 297, 1'b1);
        load_model();
        drive_packet(0);
        check("t4_pkt_len_lit", 64'(pkt_len), 64'd255);
        check("t4_overflow_lit", 64'(overflow), 64'd1);
        process_pkt(0, 1'b0);
        finish_pkt();
        check("t4_out_count_lit", 64'(out_log.size()), 64'd256);
        if (out_log.size() == 256) begin
            check("t4_word254_lit", out_log[254].data, {32'hA000_0000, 32'd254});
            check("t4_last_data_lit", out_log[255].data, {32'hA000_0000, 32'd299});
            check("t4_last_ctrl_lit", 64'(out_log[255].ctrl), 64'h01);
        end

        // Reset during send after two words
        build_packet(2, 10, 1'b0);
        load_model();
        drive_packet(0);
        process_pkt(0, 1'b0);
        cyc = 0;
        while (out_log.size() < 2 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("t5_two_words_before_reset", 64'(out_log.size() >= 2), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pkt_count   = 0;
        m_trunc_count = 0;
        check("t5_out_wr", 64'(out_wr), 64'd0);
        check("t5_in_rdy_low", 64'(in_rdy), 64'd0);
        check("t5_pkt_ready", 64'(pkt_ready), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_out_data", out_data, 64'd0);
        tick();
        check("t5_in_rdy_high", 64'(in_rdy), 64'd1);
        build_packet(3, 5, 1'b0);
        load_model();
        drive_packet(1);
        process_pkt(3, 1'b1);
        finish_pkt();

        // Randomized packets, including occasional truncation
        out_rdy_mode = 2;
        for (int p = 0; p < 20; p++) begin
            if (p == 7) build_packet(int'($urandom_range(1, 3)), int'($urandom_range(256, 270)), 1'b0);
            else        build_packet(int'($urandom_range(1, 3)), int'($urandom_range(1, 30)), 1'b0);
            load_model();
            drive_packet(int'($urandom_range(0, 2)));
            process_pkt(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            finish_pkt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_input_fifo.md
Name: pkt_input_fifo

Overview:
- Convertible packet FIFO that sits directly upstream of pipeline_datapath on the NetFPGA packet path.
- Captures one complete packet from the input stream into an internal dual-port buffer.
- Hands the buffer to the processor for read/modify, then streams the (possibly modified) packet out to the datapath's in_data/in_ctrl/in_wr interface.
- Only one packet is resident at a time: receive, process, send are mutually exclusive.

Parameters:
DATA_WIDTH, 64, packet data width
CTRL_WIDTH, DATA_WIDTH/8, control lane width
MEM_ADDR_WIDTH, 8, buffer depth 2^MEM_ADDR_WIDTH words (data+ctrl stored per word)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  upstream packet word
in_ctrl  in  CTRL_WIDTH  upstream control lane
in_wr  in  1  upstream word valid
in_rdy  out  1  ready to accept words
out_data  out  DATA_WIDTH  packet word to pipeline_datapath
out_ctrl  out  CTRL_WIDTH  control lane to pipeline_datapath
out_wr  out  1  output word valid
out_rdy  in  1  downstream may accept
proc_addr  in  MEM_ADDR_WIDTH  processor buffer address
proc_we  in  1  processor write strobe (data lane only)
proc_wdata  in  DATA_WIDTH  processor write data
proc_rdata  out  DATA_WIDTH  processor read data, 1-cycle latency
proc_done  in  1  processor finished; start send
pkt_ready  out  1  packet resident, processor owns buffer
pkt_len  out  MEM_ADDR_WIDTH  index of last stored word
overflow  out  1  current packet was truncated

Behaviour:
- States: IDLE, RX_HDR, RX_PAYLOAD, PROC, TX, TX_DRAIN. The state register and all outputs update only on the rising edge of clk.
- Reset: state=IDLE, write/read pointers=0, in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, proc_rdata=0, pkt_ready=0, pkt_len=0, overflow=0. Buffer contents are not cleared.
- in_rdy=1 only in IDLE, RX_HDR and RX_PAYLOAD.
- IDLE:
  - in_wr=1 with in_ctrl!=0 stores the word at address 0, sets wptr=1 and enters RX_HDR.
  - in_wr=1 with in_ctrl==0 is a stray word: it is discarded and the state stays IDLE.
- RX_HDR: each in_wr word is stored at wptr, then wptr increments. The first word with in_ctrl==0 enters RX_PAYLOAD.
- RX_PAYLOAD: each word is stored. A word with in_ctrl!=0 is the last word: store it, set pkt_len=wptr, go to PROC, and set pkt_ready=1 on the following cycle.
- Full buffer (wptr == 2^MEM_ADDR_WIDTH-1 and the word is not the last word):
  - store the word there and set overflow=1;
  - later words are accepted but discarded until the end-of-packet word;
  - the end-of-packet word overwrites the final address so the ctrl end marker is kept;
  - then go to PROC with pkt_len = 2^MEM_ADDR_WIDTH-1.
- PROC:
  - proc_rdata = mem[proc_addr].data, registered, valid 1 cycle after proc_addr is presented.
  - proc_we writes the data lane at proc_addr; the ctrl lane is untouched.
  - Write-then-read of the same address on the next cycle returns the new data.
  - proc_we is ignored in every state other than PROC.
  - proc_done=1 clears pkt_ready, sets rptr=0 and enters TX.
- TX: one pipeline stage of read latency.
  - A read of rptr is issued in cycle t only if out_rdy=1 at t.
  - out_wr=1 and out_data/out_ctrl = that word at t+1, regardless of out_rdy at t+1. Downstream guarantees at least 1 word of almost-full margin.
  - Stalls while out_rdy=0 produce out_wr=0 with no pointer advance.
  - After issuing the read of pkt_len, go to TX_DRAIN.
- TX_DRAIN: emit the final word, clear overflow, return to IDLE. The next packet may be accepted the cycle after IDLE is reached.
- Packet words on the output are never reordered or duplicated. Output word count = pkt_len+1.
- Simultaneous proc_we and proc_done: the write completes and the transition to TX still occurs. The first TX read sees the written data.
- Reset asserted mid-operation: the packet in flight is abandoned, all outputs take reset values on the next edge, and no partial output is emitted after reset.

Optional Feature:
- Macro PKT_INPUT_FIFO_STATS_EN.
- Defined:
  - adds output pkt_count (32 bits), incremented once per packet at TX_DRAIN→IDLE;
  - adds output trunc_count (32 bits), incremented when a packet with overflow=1 completes;
  - both are cleared by reset and wrap at 2^32.
- Undefined: neither port nor their counters exist. All other behaviour is identical.

Test Plan:
- Packet of 2 header words (ctrl 0xFF), 3 payload words (ctrl 0), 1 end word (ctrl 0x01), out_rdy=1, proc_done pulsed 1 cycle after pkt_ready → pkt_len=5, pkt_ready=1, then 6 output words with values and ctrl identical to input, in order.
- In PROC: write 0xDEADBEEF_00000000 to addr 3, read addr 3 on the next cycle → proc_rdata shows the new value after 1 cycle. Transmitted word 3 data=0xDEADBEEF_00000000 with ctrl unchanged (0).
- Toggle out_rdy as 1,0,0,1,0,1… during TX → out_wr pulses only one cycle after out_rdy=1. Total 6 words with no gap errors or duplicates.
- A 300-word packet with MEM_ADDR_WIDTH=8 → overflow=1, pkt_len=255, 256 words sent, last sent word carries the end ctrl value; overflow=0 after return to IDLE.
- Assert reset during TX after 2 words → out_wr=0 from the next edge, state IDLE, in_rdy=0 then 1. A new packet afterwards is received and sent correctly.
- With PKT_INPUT_FIFO_STATS_EN: three packets, one truncated → pkt_count=3, trunc_count=1.
